// File: rtl/keypad_entry_controller.sv
// Keypad PIN entry front end: buffers digits, streams them to an authorization
// system one per cycle, waits for its verdict and locks out after repeated denials.
module keypad_entry_controller #(
  parameter int PIN_LEN        = 4,
  parameter int RESP_TIMEOUT   = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [3:0]                         key_value,
  input  logic                               key_clear,
  input  logic                               key_enter,
  input  logic                               auth_status,
  output logic [3:0]                         code,
  output logic                               validate,
  output logic                               busy,
  output logic                               granted,
  output logic                               denied,
  output logic                               entry_error,
  output logic                               locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
  output logic [$clog2(PIN_LEN+1)-1:0]       digit_count
);

  localparam int FC_W   = $clog2(MAX_FAILS + 1);
  localparam int DC_W   = $clog2(PIN_LEN + 1);
  localparam int T_MAX1 = (PIN_LEN > RESP_TIMEOUT) ? PIN_LEN : RESP_TIMEOUT;
  localparam int T_MAX  = (T_MAX1 > LOCKOUT_CYCLES) ? T_MAX1 : LOCKOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [DC_W-1:0]  DC_FULL   = DC_W'(PIN_LEN);
  localparam logic [FC_W-1:0]  FC_LOCK   = FC_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0] SEND_LAST = TMR_W'(PIN_LEN - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, LOCK} state_t;

  state_t           state;
  logic [3:0]       buffer [PIN_LEN];
  logic [TMR_W-1:0] timer;

  // One timer serves SEND, WAIT and LOCK; it always restarts from 0 on entry.
  // NOTE: state lives in a clocked block, so every assignment here is non-blocking;
  // blocking assignments would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    granted     <= 1'b0;
    denied      <= 1'b0;
    entry_error <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      code        <= '0;
      validate    <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail_count  <= '0;
      digit_count <= '0;
      // NOTE: the digit buffer is deliberately cleared on reset so a stale PIN
      // can never be streamed out; it is only PIN_LEN nibbles wide.
      for (int i = 0; i < PIN_LEN; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_clear) begin
            digit_count <= '0;
            for (int i = 0; i < PIN_LEN; i++) buffer[i] <= '0;
          end else if (key_enter) begin
            if (digit_count == DC_FULL) begin
              // Digits leave through buffer[0]; shifting empties the buffer by itself.
              state    <= SEND;
              timer    <= '0;
              validate <= 1'b1;
              busy     <= 1'b1;
              code     <= buffer[0];
              for (int i = 0; i < PIN_LEN - 1; i++) buffer[i] <= buffer[i+1];
              buffer[PIN_LEN-1] <= '0;
            end else begin
              entry_error <= 1'b1;
              digit_count <= '0;
              for (int i = 0; i < PIN_LEN; i++) buffer[i] <= '0;
            end
          end else if (key_valid && digit_count != DC_FULL) begin
            for (int i = 0; i < PIN_LEN; i++)
              if (digit_count == DC_W'(i)) buffer[i] <= key_value;
            digit_count <= digit_count + 1'b1;
          end
        end

        SEND: begin
          if (timer == SEND_LAST) begin
            state       <= WAIT;
            timer       <= '0;
            validate    <= 1'b0;
            code        <= '0;
            digit_count <= '0;
          end else begin
            timer <= timer + 1'b1;
            code  <= buffer[0];
            for (int i = 0; i < PIN_LEN - 1; i++) buffer[i] <= buffer[i+1];
            buffer[PIN_LEN-1] <= '0;
          end
        end

        WAIT: begin
          if (auth_status) begin
            state      <= IDLE;
            granted    <= 1'b1;
            busy       <= 1'b0;
            fail_count <= '0;
          end else if (timer == WAIT_LAST) begin
            denied     <= 1'b1;
            fail_count <= fail_count + 1'b1;
            timer      <= '0;
            if (fail_count == FC_LOCK) begin
              state  <= LOCK;
              locked <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        LOCK: begin
          if (timer == LOCK_LAST) begin
            state      <= IDLE;
            locked     <= 1'b0;
            busy       <= 1'b0;
            fail_count <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Self-checking bench for keypad_entry_controller: directed vector table, corner
// sequences (lockout, reset mid-send) and random traffic against a timestamp model.
module tb_keypad_entry_controller;

  localparam int P  = 4;
  localparam int R  = 8;
  localparam int MF = 3;
  localparam int L  = 20;
  localparam int FC_W = $clog2(MF + 1);
  localparam int DC_W = $clog2(P + 1);

  logic clk, reset, key_valid, key_clear, key_enter, auth_status;
  logic [3:0] key_value, code;
  logic validate, busy, granted, denied, entry_error, locked;
  logic [FC_W-1:0] fail_count;
  logic [DC_W-1:0] digit_count;

  keypad_entry_controller #(.PIN_LEN(P), .RESP_TIMEOUT(R), .MAX_FAILS(MF),
                            .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_value(key_value),
    .key_clear(key_clear), .key_enter(key_enter), .auth_status(auth_status),
    .code(code), .validate(validate), .busy(busy), .granted(granted),
    .denied(denied), .entry_error(entry_error), .locked(locked),
    .fail_count(fail_count), .digit_count(digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {17'd0, validate, code, busy, granted, denied, entry_error, locked,
            fail_count, digit_count};
  endfunction

  // Reference model: tracks absolute edge numbers of the current submission
  // instead of a state register; outputs are what should be visible after each edge.
  int   m_q[$];
  int   m_sent[$];
  int   m_fails = 0;
  int   m_cyc = 0;
  int   m_e = 0;
  int   m_lock_e = 0;
  bit   m_active = 0;
  bit   m_locking = 0;
  logic e_validate = 0, e_busy = 0, e_granted = 0, e_denied = 0, e_err = 0, e_locked = 0;
  logic [3:0] e_code = '0;

  task automatic model_edge(input logic rst, kv, input logic [3:0] kval,
                            input logic clr, ent, auth);
    int k;
    m_cyc++;
    e_granted = 0; e_denied = 0; e_err = 0;
    if (rst) begin
      m_q.delete(); m_fails = 0; m_active = 0; m_locking = 0;
      e_validate = 0; e_code = '0; e_busy = 0; e_locked = 0;
    end else if (!m_active) begin
      if (clr) m_q.delete();
      else if (ent) begin
        if (m_q.size() == P) begin
          m_active = 1; m_locking = 0; m_e = m_cyc; m_sent = m_q;
          e_validate = 1; e_code = 4'(m_sent[0]); e_busy = 1;
        end else begin
          e_err = 1; m_q.delete();
        end
      end else if (kv && m_q.size() < P) m_q.push_back(int'(kval));
    end else begin
      k = m_cyc - m_e;
      if (k < P) e_code = 4'(m_sent[k]);
      else if (k == P) begin
        e_validate = 0; e_code = '0; m_q.delete();
      end else if (!m_locking) begin
        if (auth) begin
          e_granted = 1; m_fails = 0; m_active = 0; e_busy = 0;
        end else if (k == P + R) begin
          e_denied = 1; m_fails++;
          if (m_fails == MF) begin
            m_locking = 1; m_lock_e = m_cyc; e_locked = 1;
          end else begin
            m_active = 0; e_busy = 0;
          end
        end
      end else if (m_cyc - m_lock_e == L) begin
        e_locked = 0; m_fails = 0; m_active = 0; m_locking = 0; e_busy = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_obs();
    return {17'd0, e_validate, e_code, e_busy, e_granted, e_denied, e_err, e_locked,
            FC_W'(m_fails), DC_W'(m_q.size())};
  endfunction

  // Drive one cycle of inputs, let the DUT and model take the edge, sample 1ns later.
  task automatic tick(input int rst, kv, kval, clr, ent, auth);
    reset = 1'(rst); key_valid = 1'(kv); key_value = 4'(kval);
    key_clear = 1'(clr); key_enter = 1'(ent); auth_status = 1'(auth);
    @(posedge clk);
    model_edge(reset, key_valid, key_value, key_clear, key_enter, auth_status);
    #1;
  endtask

  task automatic type_pin(input int d0, d1, d2, d3);
    tick(0, 1, d0, 0, 0, 0); tick(0, 1, d1, 0, 0, 0);
    tick(0, 1, d2, 0, 0, 0); tick(0, 1, d3, 0, 0, 0);
  endtask

  typedef struct {
    int rst, kv, kval, clr, ent, auth;
    int v, code, busy, gr, dn, err, lk, fc, dc;
  } vec_t;

  function automatic vec_t mk(int rst, kv, kval, clr, ent, auth,
                              int v, c, b, gr, dn, err, lk, fc, dc);
    vec_t t;
    t.rst = rst; t.kv = kv; t.kval = kval; t.clr = clr; t.ent = ent; t.auth = auth;
    t.v = v; t.code = c; t.busy = b; t.gr = gr; t.dn = dn; t.err = err;
    t.lk = lk; t.fc = fc; t.dc = dc;
    return t;
  endfunction

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] exp_v;
    int den, lk, gd, seen;

    reset = 0; key_valid = 0; key_value = 0; key_clear = 0; key_enter = 0; auth_status = 0;
    @(negedge clk);

    //                 rst kv kv# clr ent au | v code bsy gr dn err lk fc dc
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 9, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 8, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 3, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 2, 1, 1, 0,  1, 7, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 9, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].kv, vecs[i].kval, vecs[i].clr, vecs[i].ent, vecs[i].auth);
      exp_v = {17'd0, 1'(vecs[i].v), 4'(vecs[i].code), 1'(vecs[i].busy), 1'(vecs[i].gr),
               1'(vecs[i].dn), 1'(vecs[i].err), 1'(vecs[i].lk), FC_W'(vecs[i].fc),
               DC_W'(vecs[i].dc)};
      check($sformatf("vec%0d", i), obs(), exp_v);
    end

    // Three denied submissions in a row lead to a lockout of exactly L cycles.
    den = 0;
    for (int s = 1; s <= MF; s++) begin
      type_pin(1, 2, 3, 4);
      tick(0, 0, 0, 0, 1, 0);
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
        tick(0, 0, 0, 0, 0, 0);
        if (denied) begin
          seen = 1; den++;
          check($sformatf("fc_after_deny%0d", s), 32'(fail_count), 32'(s));
          check($sformatf("locked_after_deny%0d", s), 32'(locked), 32'(s == MF));
        end
      end
      check($sformatf("deny_seen%0d", s), 32'(seen), 32'd1);
    end
    check("deny_count", 32'(den), 32'(MF));
    lk = locked ? 1 : 0;
    for (int c = 0; c < 60 && locked; c++) begin
      tick(0, 1, 5, 0, 1, 1);
      if (locked) lk++;
    end
    check("lock_len", 32'(lk), 32'(L));
    check("fc_after_lock", 32'(fail_count), 32'd0);
    check("busy_after_lock", 32'(busy), 32'd0);
    check("dc_after_lock", 32'(digit_count), 32'd0);

    // Reset sampled at the end of the second SEND cycle aborts the submission.
    type_pin(2, 4, 6, 8);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("send2_code", 32'(code), 32'd4);
    tick(1, 0, 0, 0, 0, 0);
    check("rst_validate", 32'(validate), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dc", 32'(digit_count), 32'd0);
    gd = 0;
    for (int c = 0; c < 30; c++) begin
      tick(0, 0, 0, 0, 0, 1);
      if (granted || denied) gd++;
    end
    check("no_verdict_after_rst", 32'(gd), 32'd0);

    // Random traffic compared every cycle against the model.
    tick(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(0, 299) == 0) ? 1 : 0,
           ($urandom_range(0, 99) < 40) ? 1 : 0,
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 4) ? 1 : 0,
           ($urandom_range(0, 99) < 12) ? 1 : 0,
           ($urandom_range(0, 99) < 12) ? 1 : 0);
      check($sformatf("rand%0d", c), obs(), model_obs());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/keypad_entry_controller.md
KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

Interface
REQ-001 Parameter PIN_LEN, default 4: number of 4-bit digits per code submission; SHALL be at least 1.
REQ-002 Parameter RESP_TIMEOUT, default 16: maximum WAIT cycles to observe auth_status high; SHALL be at least 1.
REQ-003 Parameter MAX_FAILS, default 3: consecutive denials that trigger lockout; SHALL be at least 1.
REQ-004 Parameter LOCKOUT_CYCLES, default 1000: lockout duration in clk cycles; SHALL be at least 1.
REQ-005 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- key_valid, in, 1: one-cycle digit strobe.
- key_value, in, 4: digit, sampled when key_valid=1.
- key_clear, in, 1: discard entered digits.
- key_enter, in, 1: submit entered digits.
- auth_status, in, 1: authorization result from the authorization system; 1 = granted.
- code, out, 4: digit driven toward the authorization system.
- validate, out, 1: qualifies code, one cycle per digit.
- busy, out, 1: high in SEND, WAIT, LOCK.
- granted, out, 1: one-cycle pulse on success.
- denied, out, 1: one-cycle pulse on failure.
- entry_error, out, 1: one-cycle pulse on enter with an incomplete code.
- locked, out, 1: high in LOCK.
- fail_count, out, clog2(MAX_FAILS+1): consecutive denials.
- digit_count, out, clog2(PIN_LEN+1): digits buffered.

Function
REQ-006 The FSM SHALL have four states: IDLE, SEND, WAIT, LOCK. All outputs SHALL be registered.
REQ-007 IDLE input priority SHALL be key_clear > key_enter > key_valid; only the highest-priority asserted input acts in a cycle.
REQ-008 IDLE, key_clear: buffer and digit_count SHALL clear to 0 next cycle.
REQ-009 IDLE, key_valid with digit_count<PIN_LEN: key_value SHALL be stored at index digit_count and digit_count SHALL increment; when digit_count=PIN_LEN, key_valid SHALL be ignored.
REQ-010 IDLE, key_enter with digit_count<PIN_LEN: entry_error SHALL pulse next cycle, buffer SHALL clear, and the state SHALL stay IDLE.
REQ-011 IDLE, key_enter with digit_count=PIN_LEN: the FSM SHALL enter SEND next cycle.
REQ-012 SEND SHALL last exactly PIN_LEN cycles:
- validate=1 in each cycle;
- code = buffered digit, index 0 first;
- the first validate SHALL occur one cycle after the enter cycle.
REQ-013 On leaving SEND, buffer and digit_count SHALL clear to 0, and code SHALL return to 0 with validate=0.
REQ-014 WAIT SHALL sample auth_status for up to RESP_TIMEOUT cycles, starting the cycle after the last validate.
- First sample high: granted SHALL pulse next cycle, fail_count SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-015 WAIT with no high sample in RESP_TIMEOUT cycles: denied SHALL pulse next cycle and fail_count SHALL increment.
- If the new fail_count=MAX_FAILS, the FSM SHALL enter LOCK; otherwise it SHALL go to IDLE.
REQ-016 LOCK SHALL hold locked=1 for exactly LOCKOUT_CYCLES cycles, then return to IDLE with locked=0 and fail_count=0.
REQ-017 key_valid, key_clear and key_enter SHALL be ignored in SEND, WAIT and LOCK; digits pressed there SHALL NOT be buffered.
REQ-018 fail_count SHALL never exceed MAX_FAILS, and digit_count SHALL never exceed PIN_LEN.
REQ-019 granted, denied and entry_error SHALL be mutually exclusive in any cycle.

Reset
REQ-020 reset=1 at any clock edge, including mid-SEND, mid-WAIT or mid-LOCK, SHALL take effect at that edge:
- state IDLE; buffer, digit_count, fail_count, timers cleared;
- code=0, validate=0, busy=0, granted=0, denied=0, entry_error=0, locked=0.
REQ-021 reset SHALL take priority over every other input.

Verification
REQ-022 Digits 3,7,1,9, then enter, auth_status high on the 2nd WAIT cycle -> validate high 4 consecutive cycles with code 3,7,1,9; granted pulses once; fail_count=0; digit_count=0.
REQ-023 Digits 5,5, then enter -> entry_error pulses once; digit_count=0; validate never asserts.
REQ-024 Three submissions with auth_status held 0 (LOCKOUT_CYCLES=20) -> denied pulses 3 times; fail_count=1,2,3; locked=1 for exactly 20 cycles; then fail_count=0 and IDLE.
REQ-025 key_clear and key_valid=8 in the same cycle after 2 digits -> digit_count=0; a following 5th key_valid after 4 digits -> digit_count stays 4.
REQ-026 reset asserted on the 2nd SEND cycle -> next cycle validate=0, code=0, busy=0, digit_count=0; no granted or denied pulse follows.
